// File: rtl/cv32e40p_instr_obi_responder_if.sv
// Instruction-side OBI fetch bus between the IF-stage prefetcher (master)
// and the instruction memory responder (slave).
interface cv32e40p_instr_obi_responder_if;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );
endinterface

// File: rtl/cv32e40p_instr_obi_responder.sv
// Instruction memory OBI responder: in-order word reads after a fixed latency.
// Define CV32E40P_INSTR_RESP_STALL_EN to compile in the grant-stall FSM.
module cv32e40p_instr_obi_responder #(
    parameter int unsigned MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned RESP_LATENCY    = 1,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    cv32e40p_instr_obi_responder_if.slave        bus,
    input  logic                                 init_we_i,
    input  logic [31:0]                          init_addr_i,
    input  logic [31:0]                          init_wdata_i,
    input  logic [3:0]                           stall_cycles_i,
    output logic [3:0]                           outstanding_o
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]   r_mem [MEM_WORDS];
    logic          r_vld   [RESP_LATENCY];
    logic          r_err   [RESP_LATENCY];
    logic [31:0]   r_rdata [RESP_LATENCY];
    logic [3:0]    r_outstanding;

    logic          w_gnt;
    logic          w_rvalid;
    logic          w_stall_done;
    logic          w_fetch_hit;
    logic          w_init_hit;
    logic [AW-1:0] w_fetch_idx;
    logic [AW-1:0] w_init_idx;
    logic          w_unused_addr;

    // BASE_ADDR is aligned to the memory size, so a range check is a tag compare.
    assign w_fetch_hit   = (bus.instr_addr[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_fetch_idx   = bus.instr_addr[AW+1:2];
    assign w_init_hit    = (init_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
    assign w_init_idx    = init_addr_i[AW+1:2];
    assign w_unused_addr = ^{bus.instr_addr[1:0], init_addr_i[1:0]};

    assign w_gnt    = bus.instr_req && (r_outstanding < 4'(MAX_OUTSTANDING)) && w_stall_done;
    assign w_rvalid = r_vld[RESP_LATENCY-1];

    assign bus.instr_gnt    = w_gnt;
    assign bus.instr_rvalid = w_rvalid;
    assign bus.instr_rdata  = r_rdata[RESP_LATENCY-1];
    assign bus.instr_err    = r_err[RESP_LATENCY-1];
    assign outstanding_o    = r_outstanding;

    always_ff @(posedge clk) begin
        if (init_we_i && w_init_hit) begin
            r_mem[w_init_idx] <= init_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= 4'd0;
        end else begin
            case ({w_gnt, w_rvalid})
                2'b10:   r_outstanding <= r_outstanding + 4'd1;
                2'b01:   r_outstanding <= r_outstanding - 4'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Stage 0 samples memory on the grant edge; a same-edge init write is not yet visible.
    for (genvar g = 0; g < RESP_LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_head
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[0]   <= 1'b0;
                    r_err[0]   <= 1'b0;
                    r_rdata[0] <= 32'd0;
                end else begin
                    r_vld[0]   <= w_gnt;
                    r_err[0]   <= w_gnt && !w_fetch_hit;
                    r_rdata[0] <= (w_gnt && w_fetch_hit) ? r_mem[w_fetch_idx] : 32'd0;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld[g]   <= 1'b0;
                    r_err[g]   <= 1'b0;
                    r_rdata[g] <= 32'd0;
                end else begin
                    r_vld[g]   <= r_vld[g-1];
                    r_err[g]   <= r_err[g-1];
                    r_rdata[g] <= r_rdata[g-1];
                end
            end
        end
    end

`ifdef CV32E40P_INSTR_RESP_STALL_EN
    typedef enum logic {S_IDLE, S_WAIT} stall_state_e;

    stall_state_e r_state;
    stall_state_e w_state_nxt;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_stall_done = 1'b0;
        case (r_state)
            S_IDLE:  w_stall_done = (stall_cycles_i == 4'd0);
            S_WAIT:  w_stall_done = (r_cnt == 4'd0);
            default: w_stall_done = 1'b0;
        endcase
    end

    // The refused IDLE cycle is the first stall cycle, hence the load of N-1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.instr_req && !w_gnt) begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = (stall_cycles_i == 4'd0) ? 4'd0 : stall_cycles_i - 4'd1;
                end
            end
            S_WAIT: begin
                if (!bus.instr_req || w_gnt) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt != 4'd0) begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
`else
    logic w_unused_stall;

    assign w_stall_done   = 1'b1;
    assign w_unused_stall = ^stall_cycles_i;
`endif

endmodule

// File: tb/tb_cv32e40p_instr_obi_responder.sv
// Directed bench for the instruction OBI responder: one latency-1 and one
// latency-3 instance sharing clock, reset and the preload port.
module tb_cv32e40p_instr_obi_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_we;
    logic [31:0] init_addr;
    logic [31:0] init_wdata;
    logic [3:0]  stall;
    logic [3:0]  out1;
    logic [3:0]  out3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cv32e40p_instr_obi_responder_if if1 ();
    cv32e40p_instr_obi_responder_if if3 ();

    cv32e40p_instr_obi_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_wdata_i(init_wdata),
        .stall_cycles_i(stall), .outstanding_o(out1)
    );

    cv32e40p_instr_obi_responder #(
        .MEM_WORDS(1024), .BASE_ADDR(32'h0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)
    ) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3),
        .init_we_i(init_we), .init_addr_i(init_addr), .init_wdata_i(init_wdata),
        .stall_cycles_i(stall), .outstanding_o(out3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_d [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic        t2_gnt [9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [3:0]  t2_out [9] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd2, 4'd2, 4'd1};
    logic        t2_vld [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        init_we = 1'b0; init_addr = 32'h0; init_wdata = 32'h0;
        stall = 4'd0;
        if1.instr_req = 1'b0; if1.instr_addr = 32'h0;
        if3.instr_req = 1'b0; if3.instr_addr = 32'h0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", if1.instr_rvalid, 32'd0);
        check("rst_rdata",  if1.instr_rdata,  32'd0);
        check("rst_err",    if1.instr_err,    32'd0);
        check("rst_out",    out1,             32'd0);
        check("rst_rvalid3", if3.instr_rvalid, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // Preload words 0..3 and word 5
        for (int i = 0; i < 5; i++) begin
            init_we    = 1'b1;
            init_addr  = (i == 4) ? 32'h14 : 32'(4 * i);
            init_wdata = (i == 4) ? 32'h55 : exp_d[i];
            next_cycle();
        end
        init_we = 1'b0;

`ifdef CV32E40P_INSTR_RESP_STALL_EN
        stall = 4'd0;
`else
        stall = 4'd3;
`endif

        // Back-to-back fetches, latency 1
        for (int i = 0; i < 4; i++) begin
            if1.instr_req  = 1'b1;
            if1.instr_addr = 32'(4 * i);
            @(negedge clk);
            check("t1_gnt", if1.instr_gnt, 32'd1);
            if (i > 0) begin
                check("t1_rvalid", if1.instr_rvalid, 32'd1);
                check("t1_rdata",  if1.instr_rdata,  exp_d[i-1]);
                check("t1_err",    if1.instr_err,    32'd0);
            end else begin
                check("t1_rvalid0", if1.instr_rvalid, 32'd0);
            end
            next_cycle();
        end
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t1_rvalid_last", if1.instr_rvalid, 32'd1);
        check("t1_rdata_last",  if1.instr_rdata,  32'h44);
        check("t1_out_last",    out1,             32'd1);
        next_cycle();
        @(negedge clk);
        check("t1_rvalid_idle", if1.instr_rvalid, 32'd0);
        check("t1_out_idle",    out1,             32'd0);
        next_cycle();

        // Latency 3 against MAX_OUTSTANDING 2 with continuous req
        begin
            logic [31:0] a;
            logic        g;
            int          k;
            a = 32'h0;
            k = 0;
            for (int c = 0; c < 9; c++) begin
                if3.instr_req  = (c < 8);
                if3.instr_addr = a;
                @(negedge clk);
                check($sformatf("t2_gnt_c%0d", c),    if3.instr_gnt,    32'(t2_gnt[c]));
                check($sformatf("t2_out_c%0d", c),    out3,             32'(t2_out[c]));
                check($sformatf("t2_rvalid_c%0d", c), if3.instr_rvalid, 32'(t2_vld[c]));
                if (t2_vld[c] && k < 4) begin
                    check($sformatf("t2_rdata_c%0d", c), if3.instr_rdata, exp_d[k]);
                    k++;
                end
                g = if3.instr_gnt;
                next_cycle();
                if (g) a = a + 32'd4;
            end
            @(negedge clk);
            check("t2_out_drained", out3, 32'd0);
            next_cycle();
        end

        // Out-of-range fetch, then an in-range one
        if1.instr_req  = 1'b1;
        if1.instr_addr = 32'h0000_1000;
        @(negedge clk);
        check("t3_gnt", if1.instr_gnt, 32'd1);
        next_cycle();
        if1.instr_addr = 32'h8;
        @(negedge clk);
        check("t3_oor_rvalid", if1.instr_rvalid, 32'd1);
        check("t3_oor_err",    if1.instr_err,    32'd1);
        check("t3_oor_rdata",  if1.instr_rdata,  32'd0);
        next_cycle();
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t3_ok_err",   if1.instr_err,   32'd0);
        check("t3_ok_rdata", if1.instr_rdata, 32'h33);
        next_cycle();

        // Init write and fetch of the same word in one cycle
        if1.instr_req  = 1'b1;
        if1.instr_addr = 32'h14;
        init_we        = 1'b1;
        init_addr      = 32'h14;
        init_wdata     = 32'hDEAD;
        @(negedge clk);
        check("t4_gnt", if1.instr_gnt, 32'd1);
        next_cycle();
        init_we = 1'b0;
        @(negedge clk);
        check("t4_old_rdata", if1.instr_rdata, 32'h55);
        next_cycle();
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t4_new_rdata", if1.instr_rdata, 32'hDEAD);
        next_cycle();

        // Grant stall
`ifdef CV32E40P_INSTR_RESP_STALL_EN
        stall          = 4'd3;
        if1.instr_req  = 1'b1;
        if1.instr_addr = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t5_gnt_c%0d", c), if1.instr_gnt, 32'(c == 3));
            next_cycle();
        end
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t5_rvalid", if1.instr_rvalid, 32'd1);
        check("t5_rdata",  if1.instr_rdata,  32'h11);
        next_cycle();
        stall          = 4'd0;
        if1.instr_req  = 1'b1;
        if1.instr_addr = 32'h4;
        @(negedge clk);
        check("t5_gnt_nostall", if1.instr_gnt, 32'd1);
        next_cycle();
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t5_rdata_nostall", if1.instr_rdata, 32'h22);
        next_cycle();
`else
        stall          = 4'd3;
        if1.instr_req  = 1'b1;
        if1.instr_addr = 32'h0;
        @(negedge clk);
        check("t5_gnt_nostall", if1.instr_gnt, 32'd1);
        next_cycle();
        if1.instr_req = 1'b0;
        @(negedge clk);
        check("t5_rdata", if1.instr_rdata, 32'h11);
        next_cycle();
`endif
        stall = 4'd0;

        // Reset with two responses in flight on the latency-3 instance
        if3.instr_req  = 1'b1;
        if3.instr_addr = 32'h0;
        next_cycle();
        if3.instr_addr = 32'h4;
        next_cycle();
        if3.instr_req = 1'b0;
        next_cycle();
        #2;
        check("t6_pre_rvalid", if3.instr_rvalid, 32'd1);
        check("t6_pre_rdata",  if3.instr_rdata,  32'h11);
        check("t6_pre_out",    out3,             32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rvalid", if3.instr_rvalid, 32'd0);
        check("t6_rst_rdata",  if3.instr_rdata,  32'd0);
        check("t6_rst_err",    if3.instr_err,    32'd0);
        check("t6_rst_out",    out3,             32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t6_post_rvalid_c%0d", c), if3.instr_rvalid, 32'd0);
            check($sformatf("t6_post_out_c%0d", c),    out3,             32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
